// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, opcodes and
// datapath select values, plus the control word driven by the output decoder.
package ctrl_pkg;

    typedef enum logic [3:0] {
        ST_RESET    = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_ALU_WB   = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_WB   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_HALT     = 4'd12,
        ST_TRAP     = 4'd13
    } state_e;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_ADDI = 4'h4;
    localparam logic [3:0] OP_LW   = 4'h5;
    localparam logic [3:0] OP_SW   = 4'h6;
    localparam logic [3:0] OP_BEQ  = 4'h7;
    localparam logic [3:0] OP_BNE  = 4'h8;
    localparam logic [3:0] OP_J    = 4'h9;
    localparam logic [3:0] OP_JAL  = 4'hA;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFS = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_TARGET = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       memto_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       halted;
        logic       illegal;
    } ctrl_word_t;

    function automatic logic is_rtype(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Controller <-> datapath bundle: opcode/flags/handshake in, strobes and selects out.
interface multicycle_control_if;
    logic [3:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       IRWrite;
    logic       PCWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       IorD;
    logic       RegWrite;
    logic       MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic       halted;
    logic       illegal;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output IRWrite, PCWrite, MemRead, MemWrite, IorD, RegWrite, MemtoReg,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, halted, illegal, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  IRWrite, PCWrite, MemRead, MemWrite, IorD, RegWrite, MemtoReg,
               ALUSrcA, ALUSrcB, ALUOp, PCSource, halted, illegal, state
    );
endinterface

// File: rtl/ctrl_output_decode.sv
// Combinational control-word decode: Moore by state, with mem_ready gating the
// fetch strobes and zero/opcode selecting the branch PC write.
module ctrl_output_decode
    import ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    input  logic       zero,
    output ctrl_word_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctrl.alu_src_b = SRCB_BOFS;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_FUNC;
            end
            ST_EXEC_I, ST_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ST_ALU_WB: ctrl.reg_write = 1'b1;
            ST_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ST_MEM_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.memto_reg = 1'b1;
            end
            ST_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_REG;
                ctrl.alu_op    = ALUOP_SUB;
                ctrl.pc_source = PCSRC_TARGET;
                ctrl.pc_write  = (opcode == OP_BNE) ? ~zero : zero;
            end
            ST_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
                // JAL writes the link value through the ALU-result path
                ctrl.reg_write = (opcode == OP_JAL);
            end
            ST_HALT: ctrl.halted  = 1'b1;
            ST_TRAP: ctrl.illegal = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle main control FSM: state register, next-state logic and, when
// CTRL_PERF_CNT_EN is defined, saturating cycle/instruction counters.
module multicycle_control
    import ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    multicycle_control_if.master   bus
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [15:0]            cycle_count,
    output logic [15:0]            instr_count
`endif
);

    state_e     state_reg;
    state_e     state_next;
    ctrl_word_t ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_RESET;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_RESET:  state_next = ST_FETCH;
            ST_FETCH:  if (bus.mem_ready) state_next = ST_DECODE;
            ST_DECODE: begin
                if (is_rtype(bus.opcode))                                state_next = ST_EXEC_R;
                else if (bus.opcode == OP_ADDI)                          state_next = ST_EXEC_I;
                else if (bus.opcode == OP_LW || bus.opcode == OP_SW)     state_next = ST_MEM_ADDR;
                else if (bus.opcode == OP_BEQ || bus.opcode == OP_BNE)   state_next = ST_BRANCH;
                else if (bus.opcode == OP_J || bus.opcode == OP_JAL)     state_next = ST_JUMP;
                else if (bus.opcode == OP_HALT)                          state_next = ST_HALT;
                else                                                     state_next = ST_TRAP;
            end
            ST_EXEC_R, ST_EXEC_I: state_next = ST_ALU_WB;
            ST_ALU_WB:            state_next = ST_FETCH;
            ST_MEM_ADDR: begin
                if (bus.opcode == OP_LW)      state_next = ST_MEM_RD;
                else if (bus.opcode == OP_SW) state_next = ST_MEM_WR;
                else                          state_next = ST_TRAP;
            end
            ST_MEM_RD: if (bus.mem_ready) state_next = ST_MEM_WB;
            ST_MEM_WB: state_next = ST_FETCH;
            ST_MEM_WR: if (bus.mem_ready) state_next = ST_FETCH;
            ST_BRANCH, ST_JUMP:   state_next = ST_FETCH;
            ST_HALT:   state_next = ST_HALT;
            ST_TRAP:   state_next = ST_TRAP;
            default:   state_next = ST_RESET;
        endcase
    end

    ctrl_output_decode u_output_decode (
        .state     (state_reg),
        .opcode    (bus.opcode),
        .mem_ready (bus.mem_ready),
        .zero      (bus.zero),
        .ctrl      (ctrl)
    );

    assign bus.IRWrite  = ctrl.ir_write;
    assign bus.PCWrite  = ctrl.pc_write;
    assign bus.MemRead  = ctrl.mem_read;
    assign bus.MemWrite = ctrl.mem_write;
    assign bus.IorD     = ctrl.iord;
    assign bus.RegWrite = ctrl.reg_write;
    assign bus.MemtoReg = ctrl.memto_reg;
    assign bus.ALUSrcA  = ctrl.alu_src_a;
    assign bus.ALUSrcB  = ctrl.alu_src_b;
    assign bus.ALUOp    = ctrl.alu_op;
    assign bus.PCSource = ctrl.pc_source;
    assign bus.halted   = ctrl.halted;
    assign bus.illegal  = ctrl.illegal;
    assign bus.state    = state_reg;

`ifdef CTRL_PERF_CNT_EN
    logic [15:0] cycle_count_reg;
    logic [15:0] instr_count_reg;
    logic        running;

    assign running = (state_reg != ST_RESET) && (state_reg != ST_HALT) && (state_reg != ST_TRAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count_reg <= '0;
            instr_count_reg <= '0;
        end else begin
            if (running && cycle_count_reg != 16'hFFFF)
                cycle_count_reg <= cycle_count_reg + 16'd1;
            if (state_reg == ST_FETCH && bus.mem_ready && instr_count_reg != 16'hFFFF)
                instr_count_reg <= instr_count_reg + 16'd1;
        end
    end

    assign cycle_count = cycle_count_reg;
    assign instr_count = instr_count_reg;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle vector table plus reset,
// trap/halt and (with CTRL_PERF_CNT_EN) counter sequences.
module tb_multicycle_control;

    logic clk;
    logic rst_n;
    multicycle_control_if bus ();

`ifdef CTRL_PERF_CNT_EN
    logic [15:0] cycle_count;
    logic [15:0] instr_count;
`endif

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CTRL_PERF_CNT_EN
        ,
        .cycle_count (cycle_count),
        .instr_count (instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {IRWrite PCWrite MemRead MemWrite}_{IorD RegWrite MemtoReg ALUSrcA}_{ALUSrcB ALUOp}_{PCSource halted illegal}
    localparam logic [15:0] W_ZERO   = 16'b0000_0000_0000_0000;
    localparam logic [15:0] W_FETCH  = 16'b1110_0000_0100_0000;
    localparam logic [15:0] W_FSTALL = 16'b0010_0000_0100_0000;
    localparam logic [15:0] W_DECODE = 16'b0000_0000_1100_0000;
    localparam logic [15:0] W_EXEC_R = 16'b0000_0001_0010_0000;
    localparam logic [15:0] W_EXEC_I = 16'b0000_0001_1000_0000;
    localparam logic [15:0] W_ALU_WB = 16'b0000_0100_0000_0000;
    localparam logic [15:0] W_MEM_RD = 16'b0010_1000_0000_0000;
    localparam logic [15:0] W_MEM_WB = 16'b0000_0110_0000_0000;
    localparam logic [15:0] W_MEM_WR = 16'b0001_1000_0000_0000;
    localparam logic [15:0] W_BR_T   = 16'b0100_0001_0001_0100;
    localparam logic [15:0] W_BR_NT  = 16'b0000_0001_0001_0100;
    localparam logic [15:0] W_J      = 16'b0100_0000_0000_1000;
    localparam logic [15:0] W_JAL    = 16'b0100_0100_0000_1000;
    localparam logic [15:0] W_HALT   = 16'b0000_0000_0000_0010;
    localparam logic [15:0] W_TRAP   = 16'b0000_0000_0000_0001;

    typedef struct {
        logic [3:0]  op;
        logic        mr;
        logic        z;
        logic [3:0]  st;
        logic [15:0] cw;
        string       nm;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [15:0] ctrl_now();
        return {bus.IRWrite, bus.PCWrite, bus.MemRead, bus.MemWrite,
                bus.IorD, bus.RegWrite, bus.MemtoReg, bus.ALUSrcA,
                bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.halted, bus.illegal};
    endfunction

    task automatic check(input string nm, input logic [3:0] es, input logic [15:0] ec);
        n_cmp++;
        if (bus.state !== es) begin
            n_bad++;
            $display("FAIL %s state: got %0d expected %0d", nm, bus.state, es);
        end
        n_cmp++;
        if (ctrl_now() !== ec) begin
            n_bad++;
            $display("FAIL %s ctrl: got %b expected %b", nm, ctrl_now(), ec);
        end
        $display("t=%0t %s op=%h mr=%b z=%b state=%0d ctrl=%b", $time, nm,
                 bus.opcode, bus.mem_ready, bus.zero, bus.state, ctrl_now());
    endtask

    task automatic step(input logic [3:0] op, input logic mr, input logic z,
                        input logic [3:0] es, input logic [15:0] ec, input string nm);
        @(negedge clk);
        bus.opcode    = op;
        bus.mem_ready = mr;
        bus.zero      = z;
        #1;
        check(nm, es, ec);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("reset", 4'd0, W_ZERO);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef CTRL_PERF_CNT_EN
    task automatic check_perf(input string nm, input logic [15:0] ecyc, input logic [15:0] einst);
        n_cmp++;
        if (cycle_count !== ecyc) begin
            n_bad++;
            $display("FAIL %s cycle_count: got %0d expected %0d", nm, cycle_count, ecyc);
        end
        n_cmp++;
        if (instr_count !== einst) begin
            n_bad++;
            $display("FAIL %s instr_count: got %0d expected %0d", nm, instr_count, einst);
        end
        $display("t=%0t %s cycle_count=%0d instr_count=%0d", $time, nm, cycle_count, instr_count);
    endtask
`endif

    function automatic void add(input logic [3:0] op, input logic mr, input logic z,
                                input logic [3:0] st, input logic [15:0] cw, input string nm);
        vec_t v;
        v.op = op; v.mr = mr; v.z = z; v.st = st; v.cw = cw; v.nm = nm;
        vecs.push_back(v);
    endfunction

    initial begin
        rst_n         = 1'b0;
        bus.opcode    = 4'h0;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b0;

        // ADD
        add(4'h0, 1, 0, 4'd1,  W_FETCH,  "add_fetch");
        add(4'h0, 1, 0, 4'd2,  W_DECODE, "add_decode");
        add(4'h0, 1, 0, 4'd3,  W_EXEC_R, "add_exec");
        add(4'h0, 1, 0, 4'd5,  W_ALU_WB, "add_wb");
        // LW with two MEM_RD stall cycles
        add(4'h5, 1, 0, 4'd1,  W_FETCH,  "lw_fetch");
        add(4'h5, 1, 0, 4'd2,  W_DECODE, "lw_decode");
        add(4'h5, 1, 0, 4'd6,  W_EXEC_I, "lw_addr");
        add(4'h5, 0, 0, 4'd7,  W_MEM_RD, "lw_rd_stall1");
        add(4'h5, 0, 1, 4'd7,  W_MEM_RD, "lw_rd_stall2");
        add(4'h5, 1, 0, 4'd7,  W_MEM_RD, "lw_rd_done");
        add(4'h5, 1, 0, 4'd8,  W_MEM_WB, "lw_wb");
        // SW with one fetch stall and one write stall
        add(4'h6, 0, 0, 4'd1,  W_FSTALL, "sw_fetch_stall");
        add(4'h6, 1, 0, 4'd1,  W_FETCH,  "sw_fetch");
        add(4'h6, 1, 0, 4'd2,  W_DECODE, "sw_decode");
        add(4'h6, 1, 0, 4'd6,  W_EXEC_I, "sw_addr");
        add(4'h6, 0, 0, 4'd9,  W_MEM_WR, "sw_wr_stall");
        add(4'h6, 1, 0, 4'd9,  W_MEM_WR, "sw_wr_done");
        // BNE zero=1: not taken
        add(4'h8, 1, 1, 4'd1,  W_FETCH,  "bne_z1_fetch");
        add(4'h8, 1, 1, 4'd2,  W_DECODE, "bne_z1_decode");
        add(4'h8, 1, 1, 4'd10, W_BR_NT,  "bne_z1_branch");
        // BNE zero=0: taken
        add(4'h8, 1, 0, 4'd1,  W_FETCH,  "bne_z0_fetch");
        add(4'h8, 1, 0, 4'd2,  W_DECODE, "bne_z0_decode");
        add(4'h8, 1, 0, 4'd10, W_BR_T,   "bne_z0_branch");
        // BEQ zero=1 taken, mem_ready low in BRANCH must not matter
        add(4'h7, 1, 1, 4'd1,  W_FETCH,  "beq_fetch");
        add(4'h7, 1, 1, 4'd2,  W_DECODE, "beq_decode");
        add(4'h7, 0, 1, 4'd10, W_BR_T,   "beq_branch");
        // ADDI with mem_ready low outside memory states
        add(4'h4, 1, 0, 4'd1,  W_FETCH,  "addi_fetch");
        add(4'h4, 0, 0, 4'd2,  W_DECODE, "addi_decode");
        add(4'h4, 0, 0, 4'd4,  W_EXEC_I, "addi_exec");
        add(4'h4, 0, 0, 4'd5,  W_ALU_WB, "addi_wb");
        // JAL then J
        add(4'hA, 1, 0, 4'd1,  W_FETCH,  "jal_fetch");
        add(4'hA, 1, 0, 4'd2,  W_DECODE, "jal_decode");
        add(4'hA, 1, 0, 4'd11, W_JAL,    "jal_jump");
        add(4'h9, 1, 0, 4'd1,  W_FETCH,  "j_fetch");
        add(4'h9, 1, 0, 4'd2,  W_DECODE, "j_decode");
        add(4'h9, 1, 0, 4'd11, W_J,      "j_jump");

        #1;
        check("por", 4'd0, W_ZERO);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].op, vecs[i].mr, vecs[i].z, vecs[i].st, vecs[i].cw, vecs[i].nm);

        // Reset asserted while MEM_WR is stalled
        step(4'h6, 1, 0, 4'd1, W_FETCH,  "rst_sw_fetch");
        step(4'h6, 1, 0, 4'd2, W_DECODE, "rst_sw_decode");
        step(4'h6, 1, 0, 4'd6, W_EXEC_I, "rst_sw_addr");
        step(4'h6, 0, 0, 4'd9, W_MEM_WR, "rst_sw_wr");
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_memwr", 4'd0, W_ZERO);
        @(negedge clk);
        check("rst_held", 4'd0, W_ZERO);
        rst_n = 1'b1;

        // Illegal opcode C traps and stays trapped
        step(4'hC, 1, 0, 4'd1, W_FETCH,  "trap_fetch");
        step(4'hC, 1, 0, 4'd2, W_DECODE, "trap_decode");
        for (int i = 0; i < 10; i++)
            step(4'hC, logic'(i % 2), 0, 4'd13, W_TRAP, "trap_hold");
`ifdef CTRL_PERF_CNT_EN
        check_perf("trap_perf", 16'd2, 16'd1);
`endif

        // HALT is sticky
        do_reset();
        step(4'hF, 1, 0, 4'd1, W_FETCH,  "halt_fetch");
        step(4'hF, 1, 0, 4'd2, W_DECODE, "halt_decode");
        for (int i = 0; i < 5; i++)
            step(4'hF, 1, 0, 4'd12, W_HALT, "halt_hold");
`ifdef CTRL_PERF_CNT_EN
        check_perf("halt_perf", 16'd2, 16'd1);
`endif

        // Three back-to-back jumps
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(4'h9, 1, 0, 4'd1,  W_FETCH,  "j3_fetch");
            step(4'h9, 1, 0, 4'd2,  W_DECODE, "j3_decode");
            step(4'h9, 1, 0, 4'd11, W_J,      "j3_jump");
        end
        step(4'h9, 0, 0, 4'd1, W_FSTALL, "j3_refetch");
`ifdef CTRL_PERF_CNT_EN
        check_perf("j3_perf", 16'd9, 16'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
